// File: rtl/qc_pkg.sv
// Shared types and constants for the two-qubit measurement datapath.
package qc_pkg;
  localparam int AMP_W   = 16;
  localparam int FRAC_W  = 14;
  localparam int ONE_Q14 = 16384;
  localparam int PROB_W  = 18;
  localparam int CUM_W   = 20;
  localparam int LFSR_W  = 16;

  localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

  typedef logic [1:0] basis_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SQ0,
    ST_SQ1,
    ST_SQ2,
    ST_SQ3,
    ST_DECIDE,
    ST_HOLD
  } meas_state_t;

  // Galois LFSR, shift right, mask applied when the shifted-out bit is 1.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : '0);
  endfunction
endpackage

// File: rtl/amp_mag_sq.sv
// Combinational |amp|^2 in Q.14: (re*re + im*im) >> 14, exact for -32768.
module amp_mag_sq
  import qc_pkg::*;
(
  input  logic signed [AMP_W-1:0]  re,
  input  logic signed [AMP_W-1:0]  im,
  output logic        [PROB_W-1:0] p
);
  logic signed [2*AMP_W-1:0] re_sq;
  logic signed [2*AMP_W-1:0] im_sq;
  logic        [2*AMP_W-1:0] sum;

  // Each square is at most 2^30, so the unsigned sum (<= 2^31) fits in 32 bits.
  always_comb begin
    re_sq = (2*AMP_W)'(re) * (2*AMP_W)'(re);
    im_sq = (2*AMP_W)'(im) * (2*AMP_W)'(im);
    sum   = $unsigned(re_sq) + $unsigned(im_sq);
    p     = PROB_W'(sum >> FRAC_W);
  end
endmodule

// File: rtl/two_qubit_measure.sv
// Samples a two-qubit amplitude vector with an LFSR draw and reports the outcome.
// Optional per-outcome counters are built when MEAS_STATS_EN is defined.
module two_qubit_measure
  import qc_pkg::*;
#(
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          NORM_TOL = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [AMP_W-1:0]  c00_in_re,
  input  logic signed [AMP_W-1:0]  c00_in_im,
  input  logic signed [AMP_W-1:0]  c01_in_re,
  input  logic signed [AMP_W-1:0]  c01_in_im,
  input  logic signed [AMP_W-1:0]  c10_in_re,
  input  logic signed [AMP_W-1:0]  c10_in_im,
  input  logic signed [AMP_W-1:0]  c11_in_re,
  input  logic signed [AMP_W-1:0]  c11_in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               meas,
  output logic [PROB_W-1:0]        prob_out,
  output logic                     norm_err
`ifdef MEAS_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [15:0]              cnt00,
  output logic [15:0]              cnt01,
  output logic [15:0]              cnt10,
  output logic [15:0]              cnt11
`endif
);
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 16'h0) ? 16'h0001 : SEED;

  meas_state_t              state_q, state_d;
  logic [LFSR_W-1:0]        lfsr_q, lfsr_d;
  logic signed [AMP_W-1:0]  amp_re_q [4], amp_re_d [4];
  logic signed [AMP_W-1:0]  amp_im_q [4], amp_im_d [4];
  logic [PROB_W-1:0]        p_q [4], p_d [4];
  logic [CUM_W-1:0]         cum_q [4], cum_d [4];
  basis_t                   meas_q, meas_d;
  logic [PROB_W-1:0]        prob_q, prob_d;
  logic                     norm_q, norm_d;
  logic                     out_valid_q, out_valid_d;

  logic [1:0]               sq_idx;
  logic [PROB_W-1:0]        p_cur;
  logic [CUM_W-1:0]         cum_prev;
  basis_t                   dec_meas;
  logic [CUM_W-1:0]         dev;

  always_comb begin
    case (state_q)
      ST_SQ1:  sq_idx = 2'd1;
      ST_SQ2:  sq_idx = 2'd2;
      ST_SQ3:  sq_idx = 2'd3;
      default: sq_idx = 2'd0;
    endcase
  end

  amp_mag_sq u_mag (
    .re (amp_re_q[sq_idx]),
    .im (amp_im_q[sq_idx]),
    .p  (p_cur)
  );

  always_comb begin
    cum_prev = (sq_idx == 2'd0) ? '0 : cum_q[sq_idx - 2'd1];
    // Smallest k with r < cum[k]; falls through to |11> when no bin covers r.
    dec_meas = 2'd3;
    for (int k = 3; k >= 0; k--) begin
      if (CUM_W'(lfsr_q[FRAC_W-1:0]) < cum_q[k]) dec_meas = basis_t'(k);
    end
    dev = (cum_q[3] >= CUM_W'(ONE_Q14)) ? cum_q[3] - CUM_W'(ONE_Q14)
                                        : CUM_W'(ONE_Q14) - cum_q[3];
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    amp_re_d    = amp_re_q;
    amp_im_d    = amp_im_q;
    p_d         = p_q;
    cum_d       = cum_q;
    meas_d      = meas_q;
    prob_d      = prob_q;
    norm_d      = norm_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        amp_re_d = '{c00_in_re, c01_in_re, c10_in_re, c11_in_re};
        amp_im_d = '{c00_in_im, c01_in_im, c10_in_im, c11_in_im};
        lfsr_d   = lfsr_step(lfsr_q);
        state_d  = ST_SQ0;
      end
      ST_SQ0, ST_SQ1, ST_SQ2, ST_SQ3: begin
        p_d[sq_idx]   = p_cur;
        cum_d[sq_idx] = cum_prev + CUM_W'(p_cur);
        case (state_q)
          ST_SQ0:  state_d = ST_SQ1;
          ST_SQ1:  state_d = ST_SQ2;
          ST_SQ2:  state_d = ST_SQ3;
          default: state_d = ST_DECIDE;
        endcase
      end
      ST_DECIDE: begin
        meas_d      = dec_meas;
        prob_d      = p_q[dec_meas];
        norm_d      = dev > CUM_W'(NORM_TOL);
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= SEED_EFF;
      amp_re_q    <= '{default: '0};
      amp_im_q    <= '{default: '0};
      p_q         <= '{default: '0};
      cum_q       <= '{default: '0};
      meas_q      <= '0;
      prob_q      <= '0;
      norm_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      amp_re_q    <= amp_re_d;
      amp_im_q    <= amp_im_d;
      p_q         <= p_d;
      cum_q       <= cum_d;
      meas_q      <= meas_d;
      prob_q      <= prob_d;
      norm_q      <= norm_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign meas      = meas_q;
  assign prob_out  = prob_q;
  assign norm_err  = norm_q;

`ifdef MEAS_STATS_EN
  logic [15:0] cnt_q [4], cnt_d [4];

  // Clear takes priority over a coincident transfer.
  always_comb begin
    cnt_d = cnt_q;
    if (stats_clr) begin
      cnt_d = '{default: '0};
    end else if (out_valid_q && out_ready && cnt_q[meas_q] != 16'hFFFF) begin
      cnt_d[meas_q] = cnt_q[meas_q] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '{default: '0};
    else     cnt_q <= cnt_d;
  end

  assign cnt00 = cnt_q[0];
  assign cnt01 = cnt_q[1];
  assign cnt10 = cnt_q[2];
  assign cnt11 = cnt_q[3];
`endif
endmodule

// File: tb/tb_two_qubit_measure.sv
// Randomized bench for two_qubit_measure against a behavioural probability model.
module tb_two_qubit_measure;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam int          NORM_TOL = 64;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, norm_err;
  logic signed [15:0] re_a [4];
  logic signed [15:0] im_a [4];
  logic [1:0]  meas;
  logic [17:0] prob_out;
`ifdef MEAS_STATS_EN
  logic stats_clr;
  logic [15:0] cnt00, cnt01, cnt10, cnt11;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  int exp_meas, exp_prob;
  bit exp_norm;

  two_qubit_measure #(.SEED(SEED), .NORM_TOL(NORM_TOL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .c00_in_re(re_a[0]), .c00_in_im(im_a[0]),
    .c01_in_re(re_a[1]), .c01_in_im(im_a[1]),
    .c10_in_re(re_a[2]), .c10_in_im(im_a[2]),
    .c11_in_re(re_a[3]), .c11_in_im(im_a[3]),
    .out_valid(out_valid), .out_ready(out_ready),
    .meas(meas), .prob_out(prob_out), .norm_err(norm_err)
`ifdef MEAS_STATS_EN
    , .stats_clr(stats_clr), .cnt00(cnt00), .cnt01(cnt01), .cnt10(cnt10), .cnt11(cnt11)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Outcome probabilities from the amplitudes, then inverse-CDF sampling with r.
  task automatic predict();
    longint p, cum;
    int r;
    m_lfsr   = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    r        = int'(m_lfsr) % 16384;
    cum      = 0;
    exp_meas = -1;
    exp_prob = 0;
    for (int k = 0; k < 4; k++) begin
      p   = (longint'(re_a[k]) * re_a[k] + longint'(im_a[k]) * im_a[k]) / 16384;
      cum += p;
      if (exp_meas < 0 && r < cum) begin
        exp_meas = k;
        exp_prob = int'(p);
      end
      if (k == 3 && exp_meas < 0) begin
        exp_meas = 3;
        exp_prob = int'(p);
      end
    end
    exp_norm = ((cum > 16384) ? cum - 16384 : 16384 - cum) > NORM_TOL;
  endtask

  task automatic set_amps(input int r0, input int i0, input int r1, input int i1,
                          input int r2, input int i2, input int r3, input int i3);
    re_a[0] = 16'(r0); im_a[0] = 16'(i0);
    re_a[1] = 16'(r1); im_a[1] = 16'(i1);
    re_a[2] = 16'(r2); im_a[2] = 16'(i2);
    re_a[3] = 16'(r3); im_a[3] = 16'(i3);
  endtask

  task automatic send_vec(input int hold, input bit clr_on_xfer);
    int lat;
    @(negedge clk);
    check("accept_in_ready", in_ready, 1);
    in_valid = 1'b1;
    predict();
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 5);
    check("meas", meas, exp_meas);
    check("prob_out", prob_out, exp_prob);
    check("norm_err", norm_err, exp_norm);
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
        re_a[k] = 16'($urandom);
        im_a[k] = 16'($urandom);
      end
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_meas", meas, exp_meas);
      check("hold_prob", prob_out, exp_prob);
      check("hold_norm", norm_err, exp_norm);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
`ifdef MEAS_STATS_EN
    stats_clr = clr_on_xfer;
`endif
    @(negedge clk);
    out_ready = 1'b0;
`ifdef MEAS_STATS_EN
    stats_clr = 1'b0;
`endif
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    int n0, n3, nother;
    bit seen;
    int idx;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
`ifdef MEAS_STATS_EN
    stats_clr = 1'b0;
`endif
    set_amps(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_lfsr = SEED;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_meas", meas, 0);
    check("rst_prob", prob_out, 0);
    check("rst_norm", norm_err, 0);

    set_amps(0, 0, 0, 0, 16384, 0, 0, 0);
    send_vec(0, 0);
    check("c10_meas", meas, 2);
    check("c10_prob", prob_out, 16384);
    check("c10_norm", norm_err, 0);

    set_amps(0, 0, 0, 0, 0, 0, 0, 0);
    send_vec(0, 0);
    check("zero_meas", meas, 3);
    check("zero_prob", prob_out, 0);
    check("zero_norm", norm_err, 1);

    set_amps(0, 0, 0, 16384, 0, 0, 0, 0);
    send_vec(10, 0);

    set_amps(-32768, -32768, 0, 0, 0, 0, 0, 0);
    send_vec(0, 0);
    check("max_amp_prob", prob_out, 131072);

    n0 = 0; n3 = 0; nother = 0;
    for (int v = 0; v < 1000; v++) begin
      set_amps(11585, 0, 0, 0, 0, 0, 11585, 0);
      send_vec(0, 0);
      if (meas == 2'd0) n0++;
      else if (meas == 2'd3) n3++;
      else nother++;
      if (v == 999) check("bell_prob", prob_out, 8191);
    end
    check("bell_other", nother, 0);
    check("bell_n0_range", (n0 >= 450 && n0 <= 550), 1);
    check("bell_n3_range", (n3 >= 450 && n3 <= 550), 1);

    for (int v = 0; v < 200; v++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k < 4; k++) begin
          re_a[k] = ($urandom_range(0, 7) == 0) ? 16'sh8000 : 16'($urandom);
          im_a[k] = ($urandom_range(0, 7) == 0) ? 16'sh8000 : 16'($urandom);
        end
      end else begin
        set_amps(0, 0, 0, 0, 0, 0, 0, 0);
        idx = int'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) re_a[idx] = $urandom_range(0, 1) ? 16'sd16384 : -16'sd16384;
        else                           im_a[idx] = $urandom_range(0, 1) ? 16'sd16384 : -16'sd16384;
      end
      send_vec(int'($urandom_range(0, 3)), 0);
    end

    set_amps(0, 0, 0, 0, 16384, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = SEED;
    check("abort_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_out_valid", seen, 0);
    for (int v = 0; v < 5; v++) begin
      set_amps(11585, 0, 0, 0, 0, 0, 0, 11585);
      send_vec(0, 0);
    end

`ifdef MEAS_STATS_EN
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    set_amps(0, 0, 16384, 0, 0, 0, 0, 0);
    for (int v = 0; v < 3; v++) send_vec(0, 0);
    check("stats_cnt01_3", cnt01, 3);
    check("stats_cnt00_0", cnt00, 0);
    send_vec(0, 1);
    check("stats_cnt01_clr", cnt01, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/two_qubit_measure.md
TWO_QUBIT_MEASURE -- requirements
Module: two_qubit_measure

Interface
REQ-001 Parameter SEED, default 16'hACE1: initial LFSR value; a value of 0 SHALL load 16'h0001 instead.
REQ-002 Parameter NORM_TOL, default 64: allowed |sum of probabilities − 16384| before norm_err is raised.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  amplitude vector valid.
REQ-006 in_ready  output  1  block can accept a vector.
REQ-007 cXY_in_re / cXY_in_im, XY∈{00,01,10,11}  input  16 each, signed  amplitudes of |XY>, Q1.14 format (1.0 = 16384), taken from the CNOT stage outputs.
REQ-008 out_valid  output  1  measurement result valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 meas  output  2  measured basis index: 0=|00>, 1=|01>, 2=|10>, 3=|11>.
REQ-011 prob_out  output  18, unsigned  probability of the measured outcome, Q.14 format.
REQ-012 norm_err  output  1  total probability is outside 16384±NORM_TOL.

Function
REQ-013 FSM states: IDLE, SQ0, SQ1, SQ2, SQ3, DECIDE, HOLD; in_ready SHALL equal (state==IDLE).
REQ-014 At an edge with in_valid && in_ready, all 8 amplitudes SHALL be latched and the FSM SHALL go to SQ0; the LFSR SHALL advance one step on that edge.
REQ-015 In SQk, p[k] = (re_k·re_k + im_k·im_k) >> 14 SHALL be computed with a 32-bit-exact square sum and truncation, stored as 18-bit unsigned, and added to a 20-bit cumulative sum cum[k]; the next state is SQk+1, or DECIDE after SQ3.
REQ-016 In DECIDE, r = lfsr[13:0]; meas SHALL be the smallest k with r < cum[k], or 3 if there is none.
REQ-017 In DECIDE, prob_out SHALL be set to p[meas], and norm_err to (|cum[3] − 16384| > NORM_TOL).
REQ-018 The outputs from DECIDE SHALL be registered; out_valid SHALL rise on the edge leaving DECIDE, exactly 5 cycles after the accept edge, and the FSM SHALL go to HOLD.
REQ-019 In HOLD, meas, prob_out, norm_err and out_valid SHALL stay stable until an edge with out_ready=1.
REQ-020 On that edge out_valid SHALL clear and the FSM SHALL return to IDLE; there is no overlap, so minimum spacing is 7 cycles per vector.
REQ-021 The LFSR is a 16-bit Galois LFSR, shift right, XOR mask 16'hB400 applied when the shifted-out bit is 1.
REQ-022 Amplitude −32768 is legal; the worst-case p is 131072 and SHALL not overflow 18 bits.

Reset
REQ-023 With rst high at an edge: state=IDLE, out_valid=0, meas=0, prob_out=0, norm_err=0, lfsr=SEED (or 1), cum=0.
REQ-024 Reset in any state SHALL abort the transaction with no output; in_ready SHALL be 1 in the cycle after reset.

Configuration
REQ-025 Macro MEAS_STATS_EN defined: add outputs cnt00..cnt11 (16 bits each) and input stats_clr.
REQ-026 With MEAS_STATS_EN, cnt[meas] SHALL increment on each output transfer and saturate at 16'hFFFF.
REQ-027 With MEAS_STATS_EN, stats_clr or rst SHALL zero all counters; if stats_clr and a transfer occur on the same edge, clear SHALL win.
REQ-028 Macro MEAS_STATS_EN undefined: those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-029 Shared package qc_pkg SHALL hold AMP_W=16, FRAC_W=14, ONE_Q14=16384, PROB_W=18, and the basis-index type.
REQ-030 The FSM state enum SHALL be declared in qc_pkg.
REQ-031 Sub-module amp_mag_sq SHALL be combinational, taking re and im and producing the 18-bit p; it is instantiated once and time-shared across SQ0..SQ3.

Verification
REQ-032 Stimulus c10_re=16384, all other amplitudes 0 -> meas=2, prob_out=16384, norm_err=0, out_valid exactly 5 cycles after accept.
REQ-033 Stimulus Bell state c00_re=c11_re=11585, others 0, run 1000 vectors -> meas is only ever 0 or 3, each 45–55%; prob_out=8191; norm_err=0.
REQ-034 Stimulus all amplitudes 0 -> meas=3, prob_out=0, norm_err=1.
REQ-035 Hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, a new in_valid is ignored; raising out_ready -> in_ready=1 on the next cycle.
REQ-036 Assert rst during SQ2 -> out_valid never rises; in_ready=1 the next cycle; the LFSR is reloaded to SEED.
REQ-037 With MEAS_STATS_EN, 3 transfers of |01> followed by stats_clr coincident with a 4th transfer -> cnt01 reads 3, then 0.
